mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_mul_issue_ctrl.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback sequencer for an iterative multiplier: accepts one MUL at a time,
// launches it, guards against stale/absent mul_valid, and handles flush and timeout.
module mul_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic [31:0] mul_rs1,
   output logic [31:0] mul_rs2,
   output logic        mul_signed,
   output logic        mul_start,
   input  logic [31:0] mul_result,
   input  logic        mul_valid,
   input  logic        mul_busy,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        stall,
   output logic        err_timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WB,
      S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [31:0]   rs1_q, rs1_d;
   logic [31:0]   rs2_q, rs2_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic          unused_busy;

   // Completion is signalled by mul_valid alone; busy carries no extra information here.
   assign unused_busy = mul_busy;

   assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
   assign mul_rs1    = rs1_q;
   assign mul_rs2    = rs2_q;
   assign mul_signed = 1'b0;
   assign wb_rd      = rd_q;
   assign wb_data    = wb_data_q;
   assign stall      = (state_q != S_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      wb_data_d   = wb_data_q;
      req_ready   = 1'b0;
      mul_start   = 1'b0;
      wb_valid    = 1'b0;
      err_timeout = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = !flush;
            if (req_valid && !flush) begin
               rs1_d   = req_rs1;
               rs2_d   = req_rs2;
               rd_d    = req_rd;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mul_start = 1'b1;
            cnt_d     = '0;
            state_d   = flush ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            // A mul_valid seen on the first wait cycle belongs to an older operation.
            if (cnt_q == CNT_MAX) begin
               err_timeout = 1'b1;
               state_d     = S_IDLE;
            end else if (flush) begin
               state_d = S_DRAIN;
            end else if (mul_valid && (cnt_q != '0)) begin
               wb_data_d = mul_result;
               state_d   = S_WB;
            end
         end
         S_WB: begin
            wb_valid = 1'b1;
            if (flush || wb_ready) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            cnt_d = cnt_inc;
            if (cnt_q == CNT_MAX) begin
               err_timeout = 1'b1;
               state_d     = S_IDLE;
            end else if (mul_valid && (cnt_q != '0)) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         wb_data_q <= wb_data_d;
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: multiplier stub with configurable misbehaviour plus a
// writeback scoreboard; each scenario task checks its own outcomes.
module tb_mul_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;
   logic        flush;
   logic [31:0] mul_rs1;
   logic [31:0] mul_rs2;
   logic        mul_signed;
   logic        mul_start;
   logic [31:0] mul_result;
   logic        mul_valid;
   logic        mul_busy;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall;
   logic        err_timeout;

   int checks   = 0;
   int failures = 0;

   logic [36:0] sb_q[$];

   int start_cnt   = 0;
   int wbv_cnt     = 0;
   int err_cnt     = 0;
   bit signed_seen = 1'b0;

   logic        stale_en    = 1'b0;
   logic        dbl_en      = 1'b0;
   logic        never_valid = 1'b0;
   logic        m_active;
   logic        m_second;
   int          m_elapsed;
   int          m_lat;
   logic [31:0] m_prod;

   always #5 clk = ~clk;

   mul_issue_ctrl #(.TIMEOUT_CYCLES(40)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_rd     (req_rd),
      .flush      (flush),
      .mul_rs1    (mul_rs1),
      .mul_rs2    (mul_rs2),
      .mul_signed (mul_signed),
      .mul_start  (mul_start),
      .mul_result (mul_result),
      .mul_valid  (mul_valid),
      .mul_busy   (mul_busy),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .stall      (stall),
      .err_timeout(err_timeout)
   );

   // Multiplier stub: zero operand -> valid 2 cycles after start, otherwise 18.
   always @(posedge clk) begin
      if (rst) begin
         mul_valid  <= 1'b0;
         mul_result <= '0;
         m_active   <= 1'b0;
         m_second   <= 1'b0;
         m_elapsed  <= 0;
         m_lat      <= 0;
         m_prod     <= '0;
      end else begin
         mul_valid <= 1'b0;
         if (m_second) begin
            mul_valid  <= 1'b1;
            mul_result <= ~m_prod;
            m_second   <= 1'b0;
         end
         if (mul_start) begin
            m_active  <= 1'b1;
            m_elapsed <= 1;
            m_lat     <= (mul_rs1 == 32'd0 || mul_rs2 == 32'd0) ? 2 : 18;
            m_prod    <= mul_rs1 * mul_rs2;
            if (stale_en) begin
               mul_valid  <= 1'b1;
               mul_result <= 32'hDEADBEEF;
            end
         end else if (m_active) begin
            m_elapsed <= m_elapsed + 1;
            if (m_elapsed + 1 == m_lat) begin
               m_active <= 1'b0;
               if (!never_valid) begin
                  mul_valid  <= 1'b1;
                  mul_result <= m_prod;
                  m_second   <= dbl_en;
               end
            end
         end
      end
   end
   assign mul_busy = m_active;

   always @(posedge clk) begin
      if (mul_start === 1'b1) start_cnt++;
      if (wb_valid === 1'b1) wbv_cnt++;
      if (err_timeout === 1'b1) err_cnt++;
      if (mul_signed !== 1'b0) signed_seen = 1'b1;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      int g = 0;
      while (req_ready !== 1'b1 && g < 100) begin
         @(negedge clk);
         g++;
      end
      req_valid = 1'b1;
      req_rs1   = a;
      req_rs2   = b;
      req_rd    = rd;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_wb(output int lat, output bit seen);
      int st = -1;
      seen = 1'b0;
      lat  = -1;
      for (int i = 0; i < 80; i++) begin
         if (mul_start === 1'b1 && st < 0) st = i;
         if (wb_valid === 1'b1) begin
            seen = 1'b1;
            lat  = i - st;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic sb_pop_compare(input string name);
      logic [36:0] exp;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard_empty got rd=%0d data=%h", name, wb_rd, wb_data);
      end else begin
         exp = sb_q.pop_front();
         if ({wb_rd, wb_data} !== exp) begin
            failures++;
            $display("FAIL %s got rd=%0d data=%h want rd=%0d data=%h",
                     name, wb_rd, wb_data, exp[36:32], exp[31:0]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      flush = 1'b0; wb_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({stall, wb_valid, mul_start, err_timeout, mul_signed} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=00000",
                  {stall, wb_valid, mul_start, err_timeout, mul_signed});
      end
      checks++;
      if ({wb_data, wb_rd, mul_rs1, mul_rs2} !== '0) begin
         failures++;
         $display("FAIL reset_regs got data=%h rd=%0d rs1=%h rs2=%h want 0",
                  wb_data, wb_rd, mul_rs1, mul_rs2);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_req_ready got=%b want=1", req_ready);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [31:0] ta[5]  = '{32'd7, 32'hFFFFFFFD, 32'd0, 32'h00010000, 32'hFFFFFFFF};
      logic [31:0] tb_[5] = '{32'd6, 32'd5, 32'h1234, 32'h00010000, 32'hFFFFFFFF};
      logic [4:0]  trd[5] = '{5'd5, 5'd3, 5'd9, 5'd31, 5'd1};
      logic [31:0] tex[5] = '{32'h0000002A, 32'hFFFFFFF1, 32'h0, 32'h0, 32'h1};
      int          tlat[5] = '{19, 19, 3, 19, 19};
      int lat;
      bit seen;
      int s0 = start_cnt;
      wb_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         issue(ta[k], tb_[k], trd[k]);
         sb_q.push_back({trd[k], tex[k]});
         wait_wb(lat, seen);
         checks++;
         if (!seen || lat != tlat[k]) begin
            failures++;
            $display("FAIL basic_latency[%0d] got seen=%0b lat=%0d want lat=%0d", k, seen, lat, tlat[k]);
         end
         sb_pop_compare("basic_wb");
         @(negedge clk);
         checks++;
         if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_wb_one_cycle[%0d] got=%b want=0", k, wb_valid);
         end
         $display("basic op %0d: %h * %h -> rd=%0d lat=%0d", k, ta[k], tb_[k], trd[k], lat);
      end
      checks++;
      if (start_cnt - s0 != 5) begin
         failures++;
         $display("FAIL basic_start_pulses got=%0d want=5", start_cnt - s0);
      end
      checks++;
      if (signed_seen !== 1'b0) begin
         failures++;
         $display("FAIL mul_signed_zero got=%b want=0", signed_seen);
      end
   endtask

   task automatic test_stale_valid();
      int lat;
      bit seen;
      stale_en = 1'b1;
      wb_ready = 1'b1;
      issue(32'd9, 32'd0, 5'd4);
      sb_q.push_back({5'd4, 32'd0});
      wait_wb(lat, seen);
      checks++;
      if (!seen || lat != 3) begin
         failures++;
         $display("FAIL stale_latency got seen=%0b lat=%0d want=3", seen, lat);
      end
      sb_pop_compare("stale_wb");
      stale_en = 1'b0;
      @(negedge clk);
      $display("test_stale_valid done lat=%0d", lat);
   endtask

   task automatic test_backpressure();
      int lat;
      bit seen;
      int bad = 0;
      logic [31:0] d0;
      logic [4:0]  r0;
      dbl_en   = 1'b1;
      wb_ready = 1'b0;
      issue(32'd123, 32'd456, 5'd17);
      sb_q.push_back({5'd17, 32'd56088});
      wait_wb(lat, seen);
      d0 = wb_data;
      r0 = wb_rd;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wb_valid !== 1'b1 || wb_data !== d0 || wb_rd !== r0 || req_ready !== 1'b0) bad++;
      end
      checks++;
      if (!seen || bad != 0) begin
         failures++;
         $display("FAIL bp_hold got seen=%0b unstable_cycles=%0d want 0", seen, bad);
      end
      wb_ready = 1'b1;
      sb_pop_compare("bp_wb");
      @(negedge clk);
      checks++;
      if ({wb_valid, req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL bp_release got wb_valid,req_ready=%b want=01", {wb_valid, req_ready});
      end
      dbl_en = 1'b0;
      $display("test_backpressure done");
   endtask

   task automatic test_flush_drain();
      int base = wbv_cnt;
      int k = 0;
      int mv_k = -1;
      int rr_k = -1;
      wb_ready = 1'b1;
      issue(32'd11, 32'd13, 5'd2);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      k = 4;
      for (int i = 0; i < 60; i++) begin
         if (mul_valid === 1'b1 && mv_k < 0) mv_k = k;
         if (req_ready === 1'b1) begin
            rr_k = k;
            break;
         end
         @(negedge clk);
         k++;
      end
      checks++;
      if (mv_k < 0 || rr_k != mv_k + 1) begin
         failures++;
         $display("FAIL drain_exit got valid_at=%0d ready_at=%0d want ready=valid+1", mv_k, rr_k);
      end
      checks++;
      if (wbv_cnt != base) begin
         failures++;
         $display("FAIL drain_no_wb got wb_cycles=%0d want=0", wbv_cnt - base);
      end
      $display("test_flush_drain done ready_at=%0d", rr_k);
   endtask

   task automatic test_flush_vs_valid();
      int base = wbv_cnt;
      dbl_en   = 1'b1;
      wb_ready = 1'b1;
      issue(32'd3, 32'd5, 5'd6);
      repeat (18) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (wbv_cnt != base || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_over_valid got wb_cycles=%0d req_ready=%b want 0,1",
                  wbv_cnt - base, req_ready);
      end
      dbl_en = 1'b0;
      $display("test_flush_vs_valid done");
   endtask

   task automatic test_flush_wb_idle();
      int lat;
      bit seen;
      int s0;
      wb_ready = 1'b0;
      issue(32'd2, 32'd2, 5'd8);
      wait_wb(lat, seen);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++;
      if (!seen || {wb_valid, req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL flush_in_wb got seen=%0b wb_valid,req_ready=%b want=01", seen, {wb_valid, req_ready});
      end
      wb_ready = 1'b1;
      @(negedge clk);
      s0 = start_cnt;
      req_valid = 1'b1;
      flush     = 1'b1;
      req_rs1   = 32'd1;
      req_rs2   = 32'd1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_ready got=%b want=0", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (stall !== 1'b0 || start_cnt != s0) begin
         failures++;
         $display("FAIL flush_idle_nohs got stall=%b starts=%0d want 0,0", stall, start_cnt - s0);
      end
      $display("test_flush_wb_idle done");
   endtask

   task automatic test_timeout();
      int base = wbv_cnt;
      int e0 = err_cnt;
      int st = -1;
      int off = -1;
      never_valid = 1'b1;
      wb_ready    = 1'b1;
      issue(32'd5, 32'd5, 5'd1);
      for (int i = 0; i < 80; i++) begin
         if (mul_start === 1'b1 && st < 0) st = i;
         if (err_timeout === 1'b1) begin
            off = i - st;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (off != 41) begin
         failures++;
         $display("FAIL timeout_cycle got=%0d want=41", off);
      end
      @(negedge clk);
      checks++;
      if ({err_timeout, stall} !== 2'b00 || err_cnt - e0 != 1 || wbv_cnt != base) begin
         failures++;
         $display("FAIL timeout_after got err,stall=%b pulses=%0d wb_cycles=%0d want 00,1,0",
                  {err_timeout, stall}, err_cnt - e0, wbv_cnt - base);
      end
      never_valid = 1'b0;
      $display("test_timeout done off=%0d", off);
   endtask

   task automatic test_back_to_back();
      int s0 = start_cnt;
      int popped = 0;
      int nhs = 0;
      bit hs;
      wb_ready  = 1'b1;
      req_valid = 1'b1;
      req_rs1   = 32'd100;
      req_rs2   = 32'd200;
      req_rd    = 5'd10;
      sb_q.push_back({5'd10, 32'd20000});
      for (int i = 0; i < 120 && popped < 2; i++) begin
         if (wb_valid === 1'b1) begin
            sb_pop_compare("b2b_wb");
            popped++;
         end
         hs = (req_valid === 1'b1) && (req_ready === 1'b1);
         @(negedge clk);
         if (hs) begin
            nhs++;
            if (nhs == 1) begin
               req_rs1 = 32'h0000FFFF;
               req_rs2 = 32'h0000FFFF;
               req_rd  = 5'd11;
               sb_q.push_back({5'd11, 32'hFFFE0001});
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      checks++;
      if (popped != 2 || start_cnt - s0 != 2) begin
         failures++;
         $display("FAIL b2b got writebacks=%0d starts=%0d want 2,2", popped, start_cnt - s0);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_midop();
      int base = wbv_cnt;
      issue(32'd4, 32'd4, 5'd12);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({stall, wb_valid} !== 2'b00 || mul_rs1 !== 32'd0 || wb_data !== 32'd0) begin
         failures++;
         $display("FAIL midop_reset got stall,wb_valid=%b rs1=%h data=%h want 0",
                  {stall, wb_valid}, mul_rs1, wb_data);
      end
      rst = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (wbv_cnt != base || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL midop_after got wb_cycles=%0d req_ready=%b want 0,1", wbv_cnt - base, req_ready);
      end
      $display("test_reset_midop done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stale_valid();
      test_backpressure();
      test_flush_drain();
      test_flush_vs_valid();
      test_flush_wb_idle();
      test_timeout();
      test_back_to_back();
      test_reset_midop();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
